// File: rtl/gpio_seq_pkg.sv
// -----------------------------------------------------------------------------
// gpio_seq_pkg
// Shared definitions for the GPIO power-up sequencer:
//   - state_e        : sequencer state encoding
//   - DELAY_BUS_MAX  : widest packed DELAYS bus the slice helper accepts
//   - delay_slice()  : extracts the per-channel delay k from the packed bus
// -----------------------------------------------------------------------------
package gpio_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Upper bound on CHANNELS*CNTR_WIDTH handled by delay_slice().
    localparam int DELAY_BUS_MAX = 1024;

    // Returns bits [k*w +: w] of the packed delay bus, zero-extended to 32 bits.
    // w is limited to 32; for w == 32 the mask arithmetic wraps to all ones.
    function automatic logic [31:0] delay_slice(
        input logic [DELAY_BUS_MAX-1:0] bus,
        input int                       k,
        input int                       w
    );
        logic [31:0] mask32;
        mask32 = (32'd1 << w) - 32'd1;
        return 32'(bus >> (k * w)) & mask32;
    endfunction

endpackage

// File: rtl/gpio_seq_timer.sv
// -----------------------------------------------------------------------------
// gpio_seq_timer
// Per-step delay counter for the GPIO sequencer. Counts up from zero while
// enabled and stops on reaching the limit, so it can never wrap.
//
// Ports:
//   aclk     in   clock
//   aresetn  in   asynchronous active-low reset
//   clr_i    in   synchronous clear to zero (wins over en_i)
//   en_i     in   count enable
//   limit_i  in   terminal value for the current step
//   match_o  out  counter equals limit_i (full-width compare)
//   cntr_o   out  current counter value
// -----------------------------------------------------------------------------
module gpio_seq_timer
    import gpio_seq_pkg::*;
#(
    parameter int CNTR_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [CNTR_WIDTH-1:0] limit_i,
    output logic                  match_o,
    output logic [CNTR_WIDTH-1:0] cntr_o
);

    logic [CNTR_WIDTH-1:0] cntr_q;
    logic [CNTR_WIDTH-1:0] cntr_d;

    assign match_o = (cntr_q == limit_i);
    assign cntr_o  = cntr_q;

    // Increment is gated by !match_o: the counter parks at the limit instead
    // of rolling over, even if the enable is held.
    always_comb begin
        cntr_d = cntr_q;
        if (clr_i) begin
            cntr_d = '0;
        end else if (en_i && !match_o) begin
            cntr_d = cntr_q + CNTR_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cntr_q <= '0;
        end else begin
            cntr_q <= cntr_d;
        end
    end

endmodule

// File: rtl/gpio_seq.sv
// -----------------------------------------------------------------------------
// gpio_seq
// Power-up sequencer for board GPIO lines. Releases gpio[CHANNELS-1:0] from
// their inactive to their active level strictly in ascending channel order,
// each after its own delay. hold forces every line inactive and re-arms.
//
// State table:
//   state | meaning
//   IDLE  | held (or just reset); all lines inactive, timer cleared
//   WAIT  | counting the delay of channel idx; busy high
//   DONE  | all channels released; done high, timer frozen at zero
//
// Ports:
//   aclk     in     clock
//   aresetn  in     asynchronous active-low reset
//   hold     in     synchronous; forces lines inactive and returns to IDLE
//   busy     out    high while in WAIT
//   done     out    high once every channel is released
//   gpio     inout  [CHANNELS-1:0] driven at all times, upper bits z
// -----------------------------------------------------------------------------
module gpio_seq
    import gpio_seq_pkg::*;
#(
    parameter int                   GPIO_WIDTH = 5,
    parameter int                   CHANNELS   = 1,
    parameter int                   CNTR_WIDTH = 8,
    parameter                       DELAYS     = 8'd255,
    parameter logic [CHANNELS-1:0]  ACTIVE     = '1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  hold,
    output logic                  busy,
    output logic                  done,
    inout  logic [GPIO_WIDTH-1:0] gpio
);

    localparam int IDX_W = $clog2(CHANNELS + 1);
    localparam logic [DELAY_BUS_MAX-1:0] DELAYS_EXT = DELAY_BUS_MAX'(DELAYS);

    if (CHANNELS < 1) begin : g_chk_ch_min
        $error("gpio_seq: CHANNELS must be at least 1");
    end
    if (CHANNELS > GPIO_WIDTH) begin : g_chk_ch_max
        $error("gpio_seq: CHANNELS must not exceed GPIO_WIDTH");
    end
    if ($bits(DELAYS) != CHANNELS * CNTR_WIDTH) begin : g_chk_delays
        $error("gpio_seq: DELAYS must be CHANNELS*CNTR_WIDTH bits wide");
    end
    if (CNTR_WIDTH < 1 || CNTR_WIDTH > 32) begin : g_chk_cntr
        $error("gpio_seq: CNTR_WIDTH must be in 1..32");
    end
    if (CHANNELS * CNTR_WIDTH > DELAY_BUS_MAX) begin : g_chk_bus
        $error("gpio_seq: packed DELAYS bus too wide");
    end

    state_e                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [CHANNELS-1:0]   mask_q;
    logic                  done_q;

    logic [CNTR_WIDTH-1:0] limit;
    logic [CNTR_WIDTH-1:0] cntr;
    logic                  match;
    logic                  last;
    logic                  tmr_clr;
    logic                  tmr_en;

    // Delay of the channel currently being timed. A compare-and-select over
    // the channels avoids indexing with idx, whose width is sized for
    // CHANNELS+1 and so may exceed the table's natural index width.
    always_comb begin
        limit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                limit = CNTR_WIDTH'(delay_slice(DELAYS_EXT, k, CNTR_WIDTH));
            end
        end
    end

    assign last = (idx_q == IDX_W'(CHANNELS - 1));

    // Clearing on match restarts the count for the next channel on the same
    // edge that releases the current one; outside WAIT the counter sits at 0.
    assign tmr_clr = hold || (state_q != WAIT) || match;
    assign tmr_en  = (state_q == WAIT);

    gpio_seq_timer #(
        .CNTR_WIDTH (CNTR_WIDTH)
    ) u_timer (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .limit_i (limit),
        .match_o (match),
        .cntr_o  (cntr)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
        end else if (hold) begin
            // hold outranks a compare match landing on the same edge
            state_q <= IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= WAIT;
                    idx_q   <= '0;
                end
                WAIT: begin
                    if (match) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                mask_q[k] <= 1'b1;
                            end
                        end
                        if (last) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    mask_q  <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state_q == WAIT);
    assign done = done_q;

    // Sequenced lines are driven from the mask at all times, reset included;
    // the rest of the bus is left floating.
    for (genvar k = 0; k < GPIO_WIDTH; k++) begin : g_gpio
        if (k < CHANNELS) begin : g_drv
            assign gpio[k] = mask_q[k] ? ACTIVE[k] : ~ACTIVE[k];
        end else begin : g_hiz
            assign gpio[k] = 1'bz;
        end
    end

    cntr_bounded: assert property (
        @(posedge aclk) disable iff (!aresetn)
        (state_q == WAIT) |-> (cntr <= limit)
    );

endmodule

// File: tb/tb_gpio_seq.sv
module tb_gpio_seq;

    localparam int         C3_CH  = 3;
    localparam logic [2:0] C3_ACT = 3'b101;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    // default configuration
    logic       rst_a  = 1'b0;
    logic       hold_a = 1'b0;
    logic       busy_a, done_a;
    wire  [4:0] gpio_a;

    // three channels, delays ch0=5 ch1=0 ch2=2, active 3'b101
    logic       rst_c  = 1'b0;
    logic       hold_c = 1'b0;
    logic       busy_c, done_c;
    wire  [4:0] gpio_c;

    // 4-bit counter with the maximum delay
    logic       rst_w  = 1'b0;
    logic       hold_w = 1'b0;
    logic       busy_w, done_w;
    wire  [4:0] gpio_w;

    gpio_seq u_def (
        .aclk    (aclk),
        .aresetn (rst_a),
        .hold    (hold_a),
        .busy    (busy_a),
        .done    (done_a),
        .gpio    (gpio_a)
    );

    gpio_seq #(
        .GPIO_WIDTH (5),
        .CHANNELS   (3),
        .CNTR_WIDTH (8),
        .DELAYS     ({8'd2, 8'd0, 8'd5}),
        .ACTIVE     (3'b101)
    ) u_c3 (
        .aclk    (aclk),
        .aresetn (rst_c),
        .hold    (hold_c),
        .busy    (busy_c),
        .done    (done_c),
        .gpio    (gpio_c)
    );

    gpio_seq #(
        .GPIO_WIDTH (5),
        .CHANNELS   (1),
        .CNTR_WIDTH (4),
        .DELAYS     (4'd15),
        .ACTIVE     (1'b1)
    ) u_w4 (
        .aclk    (aclk),
        .aresetn (rst_w),
        .hold    (hold_w),
        .busy    (busy_w),
        .done    (done_w),
        .gpio    (gpio_w)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int c3_dly [C3_CH] = '{5, 0, 2};

    typedef struct {
        int         edge_n;
        logic [2:0] gpio;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_c3(input string name, input logic [2:0] g, input logic b, input logic d);
        chk({name, " gpio"}, 32'(gpio_c[2:0]), 32'(g));
        chk({name, " busy"}, 32'(busy_c), 32'(b));
        chk({name, " done"}, 32'(done_c), 32'(d));
    endtask

    // Expected number of released channels, t edges after entering WAIT:
    // channel k is out once t reaches the running sum of (delay+1).
    function automatic int released(input bit run, input int t);
        int acc = 0;
        int n   = 0;
        if (!run) return 0;
        for (int k = 0; k < C3_CH; k++) begin
            acc += c3_dly[k] + 1;
            if (t >= acc) n++;
        end
        return n;
    endfunction

    function automatic logic [2:0] lines_for(input int n);
        logic [2:0] act = C3_ACT;
        logic [2:0] g;
        for (int k = 0; k < C3_CH; k++) g[k] = (k < n) ? act[k] : ~act[k];
        return g;
    endfunction

    task automatic c3_restart();
        rst_c  = 1'b0;
        hold_c = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        rst_c = 1'b1;
    endtask

    task automatic c3_edges(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Call right after reset release on a falling edge.
    task automatic run_c3_table(input string tag);
        int e = 0;
        #1;
        foreach (tbl[i]) begin
            while (e < tbl[i].edge_n) begin
                @(posedge aclk);
                #1;
                e++;
            end
            chk_c3($sformatf("%s e%0d", tag, tbl[i].edge_n), tbl[i].gpio, tbl[i].busy, tbl[i].done);
        end
    endtask

    initial begin
        bit run;
        int t;
        int n;

        tbl[0] = '{0,  3'b010, 1'b0, 1'b0};
        tbl[1] = '{1,  3'b010, 1'b1, 1'b0};
        tbl[2] = '{6,  3'b010, 1'b1, 1'b0};
        tbl[3] = '{7,  3'b011, 1'b1, 1'b0};
        tbl[4] = '{8,  3'b001, 1'b1, 1'b0};
        tbl[5] = '{10, 3'b001, 1'b1, 1'b0};
        tbl[6] = '{11, 3'b101, 1'b0, 1'b1};
        tbl[7] = '{12, 3'b101, 1'b0, 1'b1};

        // reset state, lines driven during reset
        #2;
        chk_c3("reset c3", 3'b010, 1'b0, 1'b0);
        chk("reset def gpio0", 32'(gpio_a[0]), 32'd0);
        chk("reset def busy", 32'(busy_a), 32'd0);
        chk("reset def done", 32'(done_a), 32'd0);

        // default: single line, 255 delay, release at edge 257
        @(negedge aclk);
        rst_a = 1'b1;
        for (int e = 1; e <= 260; e++) begin
            @(posedge aclk);
            #1;
            chk($sformatf("def gpio0 e%0d", e), 32'(gpio_a[0]), 32'(e >= 257));
            chk($sformatf("def done e%0d", e), 32'(done_a), 32'(e >= 257));
            chk($sformatf("def busy e%0d", e), 32'(busy_a), 32'(e < 257));
        end

        // 4-bit counter at its maximum: release at edge 17, no wrap afterwards
        @(negedge aclk);
        rst_w = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge aclk);
            #1;
            chk($sformatf("w4 gpio0 e%0d", e), 32'(gpio_w[0]), 32'(e >= 17));
            chk($sformatf("w4 done e%0d", e), 32'(done_w), 32'(e >= 17));
        end

        // three-channel clean run from the vector table
        c3_restart();
        run_c3_table("c3");

        // one-cycle hold pulse sampled at edge 9
        c3_restart();
        c3_edges(8);
        chk_c3("pulse e8", 3'b001, 1'b1, 1'b0);
        hold_c = 1'b1;
        c3_edges(1);
        chk_c3("pulse e9", 3'b010, 1'b0, 1'b0);
        hold_c = 1'b0;
        c3_edges(6);
        chk_c3("pulse e15", 3'b010, 1'b1, 1'b0);
        c3_edges(1);
        chk_c3("pulse e16", 3'b011, 1'b1, 1'b0);

        // hold on the exact edge where channel 0 matches
        c3_restart();
        c3_edges(6);
        hold_c = 1'b1;
        c3_edges(1);
        chk_c3("holdmatch e7", 3'b010, 1'b0, 1'b0);
        hold_c = 1'b0;
        c3_edges(6);
        chk_c3("holdmatch e13", 3'b010, 1'b1, 1'b0);
        c3_edges(1);
        chk_c3("holdmatch e14", 3'b011, 1'b1, 1'b0);

        // asynchronous reset between edges, then a full replay
        c3_restart();
        c3_edges(8);
        chk_c3("async pre", 3'b001, 1'b1, 1'b0);
        #2;
        rst_c = 1'b0;
        #1;
        chk_c3("async mid", 3'b010, 1'b0, 1'b0);
        @(negedge aclk);
        rst_c = 1'b1;
        run_c3_table("replay");

        // random hold traffic against the cumulative-delay model
        c3_restart();
        run = 1'b0;
        t   = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            hold_c = ($urandom_range(0, 15) == 0);
            @(posedge aclk);
            if (hold_c) begin
                run = 1'b0;
            end else if (!run) begin
                run = 1'b1;
                t   = 0;
            end else begin
                t++;
            end
            #1;
            n = released(run, t);
            chk_c3($sformatf("rand c%0d", cyc), lines_for(n), run && (n < C3_CH), n == C3_CH);
        end
        hold_c = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
